// File: rtl/player_action_controller_pkg.sv
// Shared fighter-character definitions: state codes, frame-count defaults,
// screen/sprite geometry and the frame counter width.
package char_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FWD       = 3'd1,
    ST_BACK      = 3'd2,
    ST_HITSTUN   = 3'd3,
    ST_BLOCKSTUN = 3'd4,
    ST_STARTUP   = 3'd5,
    ST_ACTIVE    = 3'd6,
    ST_RECOVERY  = 3'd7
  } state_t;

  localparam int unsigned CNT_W    = 5;
  localparam int unsigned WIDTH    = 64;
  localparam int unsigned SCREEN_W = 640;

  localparam logic [9:0] DEF_X_INIT = 10'd100;
  localparam logic [9:0] DEF_X_MIN  = 10'd0;
  localparam logic [9:0] DEF_X_MAX  = 10'(SCREEN_W - WIDTH);

  localparam int unsigned DEF_FWD_STEP   = 3;
  localparam int unsigned DEF_BACK_STEP  = 2;
  localparam int unsigned DEF_B_STARTUP  = 5;
  localparam int unsigned DEF_B_ACTIVE   = 2;
  localparam int unsigned DEF_B_RECOVERY = 16;
  localparam int unsigned DEF_D_STARTUP  = 4;
  localparam int unsigned DEF_D_ACTIVE   = 3;
  localparam int unsigned DEF_D_RECOVERY = 15;
  localparam int unsigned DEF_HITSTUN    = 12;
  localparam int unsigned DEF_BLOCKSTUN  = 8;

  // Counters run from (length-1) down to 0, so a phase spans exactly length ticks.
  function automatic logic [CNT_W-1:0] len_m1(input int unsigned len);
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/player_action_controller_if.sv
// Per-player signal bundle between debouncers/collision logic and the
// action controller, plus the controller outputs feeding renderer and hit detection.
interface player_action_controller_if;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_attack;
  logic       hit_in;
  logic [9:0] x_pos;
  logic [2:0] state;
  logic       attacking;
  logic       dir_attacking;
  logic       hit_active;
  logic       busy;

  modport master (
    output frame_tick, btn_left, btn_right, btn_attack, hit_in,
    input  x_pos, state, attacking, dir_attacking, hit_active, busy
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_attack, hit_in,
    output x_pos, state, attacking, dir_attacking, hit_active, busy
  );
endinterface

// File: rtl/player_action_controller_pulse_latch.sv
// Optional edge detector feeding a sticky pending bit; the pending output
// includes a same-cycle event so a consuming tick sees it and clears it.
module pulse_latch #(
  parameter bit EDGE_DET  = 1'b1,
  parameter bit PREV_INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  input  logic i_clr,
  output logic o_pend
);
  logic r_prev;
  logic r_pend;
  logic w_event;

  assign w_event = EDGE_DET ? (i_sig & ~r_prev) : i_sig;
  assign o_pend  = r_pend | w_event;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= PREV_INIT;
      r_pend <= 1'b0;
    end else begin
      r_prev <= i_sig;
      r_pend <= i_clr ? 1'b0 : o_pend;
    end
  end
endmodule

// File: rtl/player_action_controller.sv
// Frame-driven fighter sequencer: movement, three-phase attacks and stun.
// Define ATTACK_BUFFER_EN to buffer an attack press made during RECOVERY.
module player_action_controller
  import char_pkg::*;
#(
  parameter int unsigned PLAYER_NUM = 0,
  parameter logic [9:0]  X_INIT     = DEF_X_INIT,
  parameter logic [9:0]  X_MIN      = DEF_X_MIN,
  parameter logic [9:0]  X_MAX      = DEF_X_MAX,
  parameter int unsigned FWD_STEP   = DEF_FWD_STEP,
  parameter int unsigned BACK_STEP  = DEF_BACK_STEP,
  parameter int unsigned B_STARTUP  = DEF_B_STARTUP,
  parameter int unsigned B_ACTIVE   = DEF_B_ACTIVE,
  parameter int unsigned B_RECOVERY = DEF_B_RECOVERY,
  parameter int unsigned D_STARTUP  = DEF_D_STARTUP,
  parameter int unsigned D_ACTIVE   = DEF_D_ACTIVE,
  parameter int unsigned D_RECOVERY = DEF_D_RECOVERY,
  parameter int unsigned HITSTUN    = DEF_HITSTUN,
  parameter int unsigned BLOCKSTUN  = DEF_BLOCKSTUN
) (
  input logic                        clk,
  input logic                        rst,
  player_action_controller_if.slave  bus
);

`ifdef ATTACK_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] B_ST_M1 = len_m1(B_STARTUP);
  localparam logic [CNT_W-1:0] B_AC_M1 = len_m1(B_ACTIVE);
  localparam logic [CNT_W-1:0] B_RC_M1 = len_m1(B_RECOVERY);
  localparam logic [CNT_W-1:0] D_ST_M1 = len_m1(D_STARTUP);
  localparam logic [CNT_W-1:0] D_AC_M1 = len_m1(D_ACTIVE);
  localparam logic [CNT_W-1:0] D_RC_M1 = len_m1(D_RECOVERY);
  localparam logic [CNT_W-1:0] HS_M1   = len_m1(HITSTUN);
  localparam logic [CNT_W-1:0] BS_M1   = len_m1(BLOCKSTUN);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_kind;
  logic [9:0]       r_x;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_kind_nxt;
  logic [9:0]       w_x_nxt;

  logic w_atk_pend;
  logic w_hit_pend;
  logic w_atk_clr;
  logic w_fwd_btn;
  logic w_back_btn;
  logic w_phase;
  logic w_cnt_zero;
  logic [9:0] w_x_fwd;
  logic [9:0] w_x_back;

  function automatic logic [9:0] x_inc(input logic [9:0] x, input int unsigned step);
    logic [10:0] s;
    s = {1'b0, x} + 11'(step);
    return (s > {1'b0, X_MAX}) ? X_MAX : s[9:0];
  endfunction

  function automatic logic [9:0] x_dec(input logic [9:0] x, input int unsigned step);
    return ({1'b0, x} < ({1'b0, X_MIN} + 11'(step))) ? X_MIN : (x - 10'(step));
  endfunction

  // Forward is +x for the left player and -x for the right player.
  assign w_fwd_btn  = (PLAYER_NUM == 0) ? bus.btn_right : bus.btn_left;
  assign w_back_btn = (PLAYER_NUM == 0) ? bus.btn_left  : bus.btn_right;
  assign w_x_fwd    = (PLAYER_NUM == 0) ? x_inc(r_x, FWD_STEP)  : x_dec(r_x, FWD_STEP);
  assign w_x_back   = (PLAYER_NUM == 0) ? x_dec(r_x, BACK_STEP) : x_inc(r_x, BACK_STEP);
  assign w_cnt_zero = (r_cnt == '0);

  // A buffered press survives RECOVERY ticks until the final one consumes it.
  assign w_atk_clr = bus.frame_tick &
                     ~(BUF_EN & ~w_hit_pend & (r_state == ST_RECOVERY) & ~w_cnt_zero);

  pulse_latch #(.EDGE_DET(1'b1), .PREV_INIT(1'b1)) u_atk_latch (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (bus.btn_attack),
    .i_clr  (w_atk_clr),
    .o_pend (w_atk_pend)
  );

  pulse_latch #(.EDGE_DET(1'b0), .PREV_INIT(1'b0)) u_hit_latch (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (bus.hit_in),
    .i_clr  (bus.frame_tick),
    .o_pend (w_hit_pend)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_kind  <= 1'b0;
      r_x     <= X_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_kind  <= w_kind_nxt;
      r_x     <= w_x_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_kind_nxt  = r_kind;
    w_x_nxt     = r_x;
    if (bus.frame_tick) begin
      if (w_hit_pend) begin
        w_kind_nxt = 1'b0;
        if (r_state == ST_BACK) begin
          w_state_nxt = ST_BLOCKSTUN;
          w_cnt_nxt   = BS_M1;
        end else begin
          w_state_nxt = ST_HITSTUN;
          w_cnt_nxt   = HS_M1;
        end
      end else begin
        case (r_state)
          ST_HITSTUN, ST_BLOCKSTUN: begin
            if (w_cnt_zero) w_state_nxt = ST_IDLE;
            else            w_cnt_nxt   = r_cnt - 1'b1;
          end
          ST_STARTUP: begin
            if (w_cnt_zero) begin
              w_state_nxt = ST_ACTIVE;
              w_cnt_nxt   = r_kind ? D_AC_M1 : B_AC_M1;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (w_cnt_zero) begin
              w_state_nxt = ST_RECOVERY;
              w_cnt_nxt   = r_kind ? D_RC_M1 : B_RC_M1;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
          ST_RECOVERY: begin
            if (!w_cnt_zero) begin
              w_cnt_nxt = r_cnt - 1'b1;
            end else if (BUF_EN && w_atk_pend) begin
              w_state_nxt = ST_STARTUP;
              w_kind_nxt  = w_fwd_btn;
              w_cnt_nxt   = w_fwd_btn ? D_ST_M1 : B_ST_M1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
          default: begin
            if (w_atk_pend) begin
              w_state_nxt = ST_STARTUP;
              w_kind_nxt  = w_fwd_btn;
              w_cnt_nxt   = w_fwd_btn ? D_ST_M1 : B_ST_M1;
            end else if (w_fwd_btn && !w_back_btn) begin
              w_state_nxt = ST_FWD;
              w_x_nxt     = w_x_fwd;
            end else if (w_back_btn && !w_fwd_btn) begin
              w_state_nxt = ST_BACK;
              w_x_nxt     = w_x_back;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    w_phase           = (r_state == ST_STARTUP) || (r_state == ST_ACTIVE) ||
                        (r_state == ST_RECOVERY);
    bus.x_pos         = r_x;
    bus.state         = r_state;
    bus.attacking     = w_phase & ~r_kind;
    bus.dir_attacking = w_phase & r_kind;
    bus.hit_active    = (r_state == ST_ACTIVE);
    bus.busy          = !((r_state == ST_IDLE) || (r_state == ST_FWD) || (r_state == ST_BACK));
  end

endmodule

// File: tb/tb_player_action_controller.sv
// Scoreboard bench: two controllers (left player at x=574, right player at x=4)
// share stimulus; expected outputs are queued per tick and checked by a monitor.
`timescale 1ns/1ps
module tb_player_action_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic frame_tick = 1'b0;
  logic btn_left   = 1'b0;
  logic btn_right  = 1'b0;
  logic btn_attack = 1'b0;
  logic hit_in     = 1'b0;

  player_action_controller_if if0();
  player_action_controller_if if1();

  assign if0.frame_tick = frame_tick;
  assign if0.btn_left   = btn_left;
  assign if0.btn_right  = btn_right;
  assign if0.btn_attack = btn_attack;
  assign if0.hit_in     = hit_in;
  assign if1.frame_tick = frame_tick;
  assign if1.btn_left   = btn_left;
  assign if1.btn_right  = btn_right;
  assign if1.btn_attack = btn_attack;
  assign if1.hit_in     = hit_in;

  player_action_controller #(.PLAYER_NUM(0), .X_INIT(10'd574)) u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  player_action_controller #(.PLAYER_NUM(1), .X_INIT(10'd4)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] x;
    logic       atk;
    logic       datk;
    logic       hact;
    logic       busy;
  } obs_t;

  typedef struct {
    int   tag;
    int   idx;
    bit   c0;
    bit   c1;
    obs_t e0;
    obs_t e1;
  } sb_t;

  sb_t  sbq[$];
  int   checks    = 0;
  int   failures  = 0;
  bit   req_async = 1'b0;
  event ev_chk;

  localparam bit BUF_EN =
`ifdef ATTACK_BUFFER_EN
    1'b1;
`else
    1'b0;
`endif

  function automatic obs_t mk(input logic [2:0] st, input logic [9:0] x, input logic kind);
    obs_t o;
    logic ph;
    ph     = (st >= 3'd5);
    o.st   = st;
    o.x    = x;
    o.atk  = ph & ~kind;
    o.datk = ph & kind;
    o.hact = (st == 3'd6);
    o.busy = (st >= 3'd3);
    return o;
  endfunction

  task automatic cmp(input int tag, input int idx, input int dut, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL t%0d_i%0d_u%0d actual st=%0d x=%0d atk=%b datk=%b hact=%b busy=%b required st=%0d x=%0d atk=%b datk=%b hact=%b busy=%b",
               tag, idx, dut, act.st, act.x, act.atk, act.datk, act.hact, act.busy,
               exp.st, exp.x, exp.atk, exp.datk, exp.hact, exp.busy);
    end
  endtask

  // Monitor: outputs are presented on every tick edge (or on an async reset probe).
  initial begin
    sb_t  e;
    obs_t a0, a1;
    forever begin
      @(posedge clk or ev_chk);
      if (frame_tick || req_async) begin
        #1;
        req_async = 1'b0;
        a0 = {if0.state, if0.x_pos, if0.attacking, if0.dir_attacking, if0.hit_active, if0.busy};
        a1 = {if1.state, if1.x_pos, if1.attacking, if1.dir_attacking, if1.hit_active, if1.busy};
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty actual size=0 required size>0");
        end else begin
          e = sbq.pop_front();
          if (e.c0) cmp(e.tag, e.idx, 0, a0, e.e0);
          if (e.c1) cmp(e.tag, e.idx, 1, a1, e.e1);
        end
      end
    end
  end

  task automatic push(input int tag, input int idx, input bit c0, input obs_t e0,
                      input bit c1, input obs_t e1);
    sb_t s;
    s.tag = tag; s.idx = idx; s.c0 = c0; s.c1 = c1; s.e0 = e0; s.e1 = e1;
    sbq.push_back(s);
  endtask

  task automatic tick(input int tag, input int idx, input bit c0, input obs_t e0,
                      input bit c1, input obs_t e1);
    push(tag, idx, c0, e0, c1, e1);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_now(input int tag, input obs_t e0, input obs_t e1);
    push(tag, 0, 1'b1, e0, 1'b1, e1);
    req_async = 1'b1;
    -> ev_chk;
    #2;
  endtask

  task automatic pulse_attack();
    btn_attack = 1'b1;
    @(negedge clk);
    btn_attack = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_hit();
    hit_in = 1'b1;
    @(negedge clk);
    hit_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [2:0] basic_st(input int i);
    return (i <= 5) ? 3'd5 : (i <= 7) ? 3'd6 : (i <= 23) ? 3'd7 : 3'd0;
  endfunction

  function automatic logic [2:0] dir_st(input int i);
    return (i <= 4) ? 3'd5 : (i <= 7) ? 3'd6 : (i <= 22) ? 3'd7 : 3'd0;
  endfunction

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_now(0, mk(3'd0, 10'd574, 1'b0), mk(3'd0, 10'd4, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic attack on both players: 5/2/16 then idle, x frozen.
    pulse_attack();
    for (int i = 1; i <= 24; i++)
      tick(1, i, 1'b1, mk(basic_st(i), 10'd574, 1'b0), 1'b1, mk(basic_st(i), 10'd4, 1'b0));

    // Movement and clamps at both ends of the screen.
    btn_right = 1'b1;
    tick(2, 1, 1'b1, mk(3'd1, 10'd576, 1'b0), 1'b1, mk(3'd2, 10'd6, 1'b0));
    tick(2, 2, 1'b1, mk(3'd1, 10'd576, 1'b0), 1'b1, mk(3'd2, 10'd8, 1'b0));
    btn_left = 1'b1;
    tick(2, 3, 1'b1, mk(3'd0, 10'd576, 1'b0), 1'b1, mk(3'd0, 10'd8, 1'b0));
    btn_right = 1'b0;
    tick(2, 4, 1'b1, mk(3'd2, 10'd574, 1'b0), 1'b1, mk(3'd1, 10'd5, 1'b0));
    tick(2, 5, 1'b1, mk(3'd2, 10'd572, 1'b0), 1'b1, mk(3'd1, 10'd2, 1'b0));
    tick(2, 6, 1'b1, mk(3'd2, 10'd570, 1'b0), 1'b1, mk(3'd1, 10'd0, 1'b0));
    tick(2, 7, 1'b1, mk(3'd2, 10'd568, 1'b0), 1'b1, mk(3'd1, 10'd0, 1'b0));
    btn_left = 1'b0;
    tick(2, 8, 1'b1, mk(3'd0, 10'd568, 1'b0), 1'b1, mk(3'd0, 10'd0, 1'b0));

    // Directional attack for the right player (left = forward); second press ignored.
    reset_all();
    btn_left = 1'b1;
    pulse_attack();
    tick(3, 1, 1'b1, mk(3'd5, 10'd574, 1'b0), 1'b1, mk(3'd5, 10'd4, 1'b1));
    btn_left = 1'b0;
    pulse_attack();
    for (int i = 2; i <= 24; i++)
      tick(3, i, 1'b1, mk(basic_st(i), 10'd574, 1'b0), 1'b1, mk(dir_st(i), 10'd4, 1'b1));

    // Hit while walking: left player backing -> blockstun 8, right player -> hitstun 12.
    reset_all();
    btn_left = 1'b1;
    tick(4, 1, 1'b1, mk(3'd2, 10'd572, 1'b0), 1'b1, mk(3'd1, 10'd1, 1'b0));
    pulse_hit();
    btn_left = 1'b0;
    for (int i = 1; i <= 13; i++)
      tick(4, 1 + i, 1'b1, mk((i <= 8) ? 3'd4 : 3'd0, 10'd572, 1'b0),
           1'b1, mk((i <= 12) ? 3'd3 : 3'd0, 10'd1, 1'b0));

    // Hit during STARTUP, then a re-hit at stun tick 6 restarts the 12-tick stun.
    reset_all();
    pulse_attack();
    tick(5, 1, 1'b1, mk(3'd5, 10'd574, 1'b0), 1'b1, mk(3'd5, 10'd4, 1'b0));
    for (int i = 2; i <= 18; i++) begin
      if (i == 2 || i == 6) pulse_hit();
      tick(5, i, 1'b1, mk((i <= 17) ? 3'd3 : 3'd0, 10'd574, 1'b0),
           1'b1, mk((i <= 17) ? 3'd3 : 3'd0, 10'd4, 1'b0));
    end

    // Asynchronous reset during ACTIVE, released with attack held.
    reset_all();
    pulse_attack();
    for (int i = 1; i <= 6; i++)
      tick(6, i, 1'b1, mk(basic_st(i), 10'd574, 1'b0), 1'b1, mk(basic_st(i), 10'd4, 1'b0));
    btn_attack = 1'b1;
    #2;
    rst = 1'b1;
    check_now(6, mk(3'd0, 10'd574, 1'b0), mk(3'd0, 10'd4, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tick(6, 7, 1'b1, mk(3'd0, 10'd574, 1'b0), 1'b1, mk(3'd0, 10'd4, 1'b0));
    btn_attack = 1'b0;
    tick(6, 8, 1'b1, mk(3'd0, 10'd574, 1'b0), 1'b1, mk(3'd0, 10'd4, 1'b0));

    // Press during RECOVERY: buffered build chains into STARTUP, default build drops it.
    reset_all();
    pulse_attack();
    for (int i = 1; i <= 8; i++)
      tick(7, i, 1'b1, mk(basic_st(i), 10'd574, 1'b0), 1'b1, mk(basic_st(i), 10'd4, 1'b0));
    pulse_attack();
    for (int i = 9; i <= 25; i++) begin
      logic [2:0] s;
      s = (i <= 23) ? 3'd7 : (BUF_EN ? 3'd5 : 3'd0);
      tick(7, i, 1'b1, mk(s, 10'd574, 1'b0), 1'b1, mk(s, 10'd4, 1'b0));
    end

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual size=%0d required size=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
